// File: rtl/blur_writeback.sv
// -----------------------------------------------------------------------------
// blur_writeback
//
// Write-back stage of the Gaussian blur pipeline. Blurred pixels arriving from
// the convolution engine are buffered in a small FIFO and written into the
// output image memory. Write addresses are generated in the same traversal
// order the convolution engine uses to read its input. frame_done pulses once
// the last pixel of the frame has been committed.
//
// Ports:
//   clk         system clock
//   n_rst       asynchronous active-low reset
//   new_trans   frame start: flushes FIFO, resets position/flags, samples max_x/max_y
//   max_x       last column index of the frame (width-1)
//   max_y       last row index of the frame (height-1)
//   pix_valid   one-cycle strobe, blurred pixel available
//   pix_data    blurred pixel value
//   wbusy       memory cannot accept a write this cycle
//   wen_img     write enable (held while wbusy=1)
//   wdat_img    write data
//   x_addr_img  write column
//   y_addr_img  write row
//   frame_done  one-cycle pulse the cycle after the final write completes
//   err         sticky: a pixel was dropped (overflow, excess or out of frame)
//
// Build option:
//   BLUR_WB_RASTER_EN  when defined, addresses follow raster order; otherwise
//                      serpentine order (even rows left-to-right, odd rows
//                      right-to-left).
// -----------------------------------------------------------------------------
module blur_writeback #(
  parameter int MEM_W      = 200,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = $clog2(MEM_W)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              new_trans,
  input  logic [ADDR_W-1:0] max_x,
  input  logic [ADDR_W-1:0] max_y,
  input  logic              pix_valid,
  input  logic [7:0]        pix_data,
  input  logic              wbusy,
  output logic              wen_img,
  output logic [7:0]        wdat_img,
  output logic [ADDR_W-1:0] x_addr_img,
  output logic [ADDR_W-1:0] y_addr_img,
  output logic              frame_done,
  output logic              err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t            r_state;
  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [ADDR_W-1:0] r_max_x;
  logic [ADDR_W-1:0] r_max_y;
  logic [ADDR_W-1:0] r_x;        // position of the pixel currently offered for write
  logic [ADDR_W-1:0] r_y;
  logic [ADDR_W-1:0] r_in_x;     // receive-side position, used only to count pixels
  logic [ADDR_W-1:0] r_in_y;
  logic              r_in_done;  // every pixel of the frame has been accepted
  logic              r_wen;
  logic [7:0]        r_wdat;
  logic              r_frame_done;
  logic              r_err;

  logic              w_active;
  logic              w_full;
  logic              w_wr_done;
  logic              w_push;
  logic              w_drop;
  logic              w_last;
  logic [ADDR_W-1:0] w_last_x;
  logic [ADDR_W-1:0] w_x_nxt;
  logic [ADDR_W-1:0] w_y_nxt;
  logic [ADDR_W-1:0] w_in_x_nxt;
  logic [ADDR_W-1:0] w_in_y_nxt;
  logic              w_in_done_nxt;
  logic [PTR_W-1:0]  w_rd_ptr_nxt;
  logic [CNT_W-1:0]  w_cnt_popped;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [7:0]        w_head_nxt;
  state_t            w_state_nxt;

  // FIFO handshake, occupancy and next head-of-queue selection
  always_comb begin
    w_active  = (r_state == S_ACTIVE);
    w_full    = (r_count == FULL_CNT);
    // r_wen is only ever set in ACTIVE, so this is a completed memory write
    w_wr_done = r_wen & ~wbusy;
    // a full FIFO still accepts when its head leaves in the same cycle
    w_push    = w_active & pix_valid & ~new_trans & ~r_in_done & (~w_full | w_wr_done);
    w_drop    = pix_valid & ~new_trans & ~w_push;

    if (w_wr_done) begin
      w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
      w_cnt_popped = r_count - CNT_W'(1);
    end else begin
      w_rd_ptr_nxt = r_rd_ptr;
      w_cnt_popped = r_count;
    end

    if (w_push) begin
      w_cnt_nxt = w_cnt_popped + CNT_W'(1);
    end else begin
      w_cnt_nxt = w_cnt_popped;
    end

    // the incoming pixel becomes the head only when nothing older remains,
    // giving the one-cycle enqueue-to-write latency
    if (w_push && (w_cnt_popped == {CNT_W{1'b0}})) begin
      w_head_nxt = pix_data;
    end else begin
      w_head_nxt = r_mem[w_rd_ptr_nxt];
    end
  end

  // Write-address traversal and last-pixel detection
  always_comb begin
`ifdef BLUR_WB_RASTER_EN
    w_last_x = r_max_x;
    if (r_x == r_max_x) begin
      w_x_nxt = {ADDR_W{1'b0}};
      w_y_nxt = r_y + ADDR_W'(1);
    end else begin
      w_x_nxt = r_x + ADDR_W'(1);
      w_y_nxt = r_y;
    end
`else
    // the frame ends on the right edge for an odd row count, left edge otherwise
    w_last_x = r_max_y[0] ? {ADDR_W{1'b0}} : r_max_x;
    if (!r_y[0]) begin
      if (r_x == r_max_x) begin
        w_x_nxt = r_x;
        w_y_nxt = r_y + ADDR_W'(1);
      end else begin
        w_x_nxt = r_x + ADDR_W'(1);
        w_y_nxt = r_y;
      end
    end else begin
      if (r_x == {ADDR_W{1'b0}}) begin
        w_x_nxt = r_x;
        w_y_nxt = r_y + ADDR_W'(1);
      end else begin
        w_x_nxt = r_x - ADDR_W'(1);
        w_y_nxt = r_y;
      end
    end
`endif
    w_last = (r_y == r_max_y) && (r_x == w_last_x);

    if (w_wr_done && w_last) begin
      w_state_nxt = S_DONE;
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Receive-side pixel counter; order is irrelevant, only the total matters
  always_comb begin
    if (r_in_x == r_max_x) begin
      w_in_x_nxt = {ADDR_W{1'b0}};
      if (r_in_y == r_max_y) begin
        w_in_y_nxt    = r_in_y;
        w_in_done_nxt = 1'b1;
      end else begin
        w_in_y_nxt    = r_in_y + ADDR_W'(1);
        w_in_done_nxt = 1'b0;
      end
    end else begin
      w_in_x_nxt    = r_in_x + ADDR_W'(1);
      w_in_y_nxt    = r_in_y;
      w_in_done_nxt = 1'b0;
    end
  end

  // FIFO storage (data only, validity is tracked by r_count)
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= pix_data;
    end
  end

  // Frame FSM, FIFO pointers, positions and registered outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= {PTR_W{1'b0}};
      r_rd_ptr     <= {PTR_W{1'b0}};
      r_count      <= {CNT_W{1'b0}};
      r_max_x      <= {ADDR_W{1'b0}};
      r_max_y      <= {ADDR_W{1'b0}};
      r_x          <= {ADDR_W{1'b0}};
      r_y          <= {ADDR_W{1'b0}};
      r_in_x       <= {ADDR_W{1'b0}};
      r_in_y       <= {ADDR_W{1'b0}};
      r_in_done    <= 1'b0;
      r_wen        <= 1'b0;
      r_wdat       <= 8'd0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
    end else if (new_trans) begin
      // frame restart wins over any write or pixel in the same cycle
      r_state      <= S_ACTIVE;
      r_wr_ptr     <= {PTR_W{1'b0}};
      r_rd_ptr     <= {PTR_W{1'b0}};
      r_count      <= {CNT_W{1'b0}};
      r_max_x      <= max_x;
      r_max_y      <= max_y;
      r_x          <= {ADDR_W{1'b0}};
      r_y          <= {ADDR_W{1'b0}};
      r_in_x       <= {ADDR_W{1'b0}};
      r_in_y       <= {ADDR_W{1'b0}};
      r_in_done    <= 1'b0;
      r_wen        <= 1'b0;
      r_wdat       <= 8'd0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_cnt_nxt;
      if (w_push) begin
        r_wr_ptr  <= r_wr_ptr + PTR_W'(1);
        r_in_x    <= w_in_x_nxt;
        r_in_y    <= w_in_y_nxt;
        r_in_done <= w_in_done_nxt;
      end
      // the position stays on the final pixel once the frame completes
      if (w_wr_done && !w_last) begin
        r_x <= w_x_nxt;
        r_y <= w_y_nxt;
      end
      r_wen <= (w_state_nxt == S_ACTIVE) && (w_cnt_nxt != {CNT_W{1'b0}});
      if (w_cnt_nxt != {CNT_W{1'b0}}) begin
        r_wdat <= w_head_nxt;
      end
      r_frame_done <= w_wr_done & w_last;
      if (w_drop) begin
        r_err <= 1'b1;
      end
    end
  end

  assign wen_img    = r_wen;
  assign wdat_img   = r_wdat;
  assign x_addr_img = r_x;
  assign y_addr_img = r_y;
  assign frame_done = r_frame_done;
  assign err        = r_err;

endmodule

// File: tb/tb_blur_writeback.sv
// -----------------------------------------------------------------------------
// tb_blur_writeback
//
// Self-checking bench for blur_writeback. Accepted pixels are pushed with their
// expected address onto a scoreboard; a negedge monitor pops and compares on
// every completed write and checks frame_done timing. A table of frame shapes
// is applied in a loop, followed by hand-written backpressure, full-FIFO and
// mid-frame restart sequences.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_blur_writeback;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          new_trans = 1'b0;
  logic [AW-1:0] max_x = 8'd0;
  logic [AW-1:0] max_y = 8'd0;
  logic          pix_valid = 1'b0;
  logic [7:0]    pix_data = 8'd0;
  logic          wbusy = 1'b0;
  logic          wen_img;
  logic [7:0]    wdat_img;
  logic [AW-1:0] x_addr_img;
  logic [AW-1:0] y_addr_img;
  logic          frame_done;
  logic          err;

  blur_writeback #(.MEM_W(200), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .new_trans  (new_trans),
    .max_x      (max_x),
    .max_y      (max_y),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .wbusy      (wbusy),
    .wen_img    (wen_img),
    .wdat_img   (wdat_img),
    .x_addr_img (x_addr_img),
    .y_addr_img (y_addr_img),
    .frame_done (frame_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int d;
    bit last;
  } exp_t;

  typedef struct {
    int mx;
    int my;
    int npix;
    int gap;
    bit exp_err;
    int exp_done;
  } vec_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_mis = 0;
  int   cyc = 0;
  int   last_cyc = -10;
  int   done_cnt = 0;
  int   acc_idx = 0;
  int   cur_mx = 0;
  int   cur_my = 0;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // reference traversal: pixel index -> address
  function automatic void pos_of(input int idx, input int mx, output int x, output int y);
    int c;
    y = idx / (mx + 1);
    c = idx % (mx + 1);
`ifdef BLUR_WB_RASTER_EN
    x = c;
`else
    x = (y % 2 == 0) ? c : (mx - c);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int mx, input int my, input bit with_pix);
    new_trans = 1'b1;
    max_x     = AW'(mx);
    max_y     = AW'(my);
    pix_valid = with_pix;
    pix_data  = 8'hEE;
    tick();
    new_trans = 1'b0;
    pix_valid = 1'b0;
    sb.delete();
    acc_idx  = 0;
    cur_mx   = mx;
    cur_my   = my;
    done_cnt = 0;
  endtask

  task automatic drive_pix(input int d, input bit accept);
    exp_t e;
    int   x;
    int   y;
    pix_valid = 1'b1;
    pix_data  = 8'(d);
    if (accept) begin
      pos_of(acc_idx, cur_mx, x, y);
      e.x    = x;
      e.y    = y;
      e.d    = d;
      e.last = (acc_idx == (cur_mx + 1) * (cur_my + 1) - 1);
      sb.push_back(e);
      acc_idx++;
    end
    tick();
    pix_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300 && sb.size() != 0; i++) tick();
    check({name, "_drained"}, sb.size(), 0);
    repeat (3) tick();
  endtask

  // write/frame_done monitor, sampled away from the active edge
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (n_rst && wen_img && !wbusy) begin
      if (sb.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        e = sb.pop_front();
        check("wr_x", int'(x_addr_img), e.x);
        check("wr_y", int'(y_addr_img), e.y);
        check("wr_data", int'(wdat_img), e.d);
        if (e.last) last_cyc = cyc;
      end
    end
    if (n_rst && frame_done) begin
      done_cnt++;
      check("done_timing", cyc, last_cyc + 1);
      check("done_wen_low", int'(wen_img), 0);
    end
  end

  initial begin
    vec_t vt[6];
    vt[0] = '{2, 1, 6, 0, 1'b0, 1};   // serpentine 3x2, data 10..15
    vt[1] = '{0, 0, 1, 0, 1'b0, 1};   // one-pixel frame
    vt[2] = '{3, 2, 12, 1, 1'b0, 1};
    vt[3] = '{2, 1, 7, 0, 1'b1, 1};   // seventh pixel is excess
    vt[4] = '{1, 3, 8, 2, 1'b0, 1};
    vt[5] = '{4, 0, 5, 0, 1'b0, 1};

    // reset values
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", int'({wen_img, wdat_img, x_addr_img, y_addr_img, frame_done, err}), 0);
    n_rst = 1'b1;
    tick();

    // pixel while IDLE is dropped
    drive_pix(8'h55, 1'b0);
    check("idle_pix_err", int'(err), 1);
    repeat (2) tick();

    // table of frames
    for (int v = 0; v < 6; v++) begin
      int total;
      total = (vt[v].mx + 1) * (vt[v].my + 1);
      start_frame(vt[v].mx, vt[v].my, 1'b0);
      for (int i = 0; i < vt[v].npix; i++) begin
        drive_pix(10 + i, i < total);
        repeat (vt[v].gap) tick();
      end
      drain($sformatf("vec%0d", v));
      check($sformatf("vec%0d_err", v), int'(err), int'(vt[v].exp_err));
      check($sformatf("vec%0d_done_cnt", v), done_cnt, vt[v].exp_done);
      check($sformatf("vec%0d_wen_idle", v), int'(wen_img), 0);
    end

    // backpressure: outputs hold while busy, overflow drops and flags
    start_frame(2, 1, 1'b0);
    wbusy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_pix(40 + i, 1'b1);
      check("bp_hold", int'({wen_img, wdat_img, x_addr_img, y_addr_img}), int'({1'b1, 8'd40, 8'd0, 8'd0}));
      check("bp_err_clear", int'(err), 0);
    end
    drive_pix(44, 1'b0);
    check("bp_hold_full", int'({wen_img, wdat_img, x_addr_img, y_addr_img}), int'({1'b1, 8'd40, 8'd0, 8'd0}));
    check("bp_overflow_err", int'(err), 1);
    wbusy = 1'b0;
    drive_pix(45, 1'b1);
    drive_pix(46, 1'b1);
    drain("bp");
    check("bp_done_cnt", done_cnt, 1);

    // full FIFO with a write in the same cycle keeps accepting
    start_frame(3, 1, 1'b0);
    wbusy = 1'b1;
    for (int i = 0; i < 4; i++) drive_pix(60 + i, 1'b1);
    wbusy = 1'b0;
    drive_pix(64, 1'b1);
    check("full_simul_err", int'(err), 0);
    wbusy = 1'b1;
    drive_pix(65, 1'b0);   // occupancy is still four, so this one overflows
    check("full_occupancy_err", int'(err), 1);
    wbusy = 1'b0;
    drive_pix(66, 1'b1);
    drive_pix(67, 1'b1);
    drive_pix(68, 1'b1);
    drain("full");
    check("full_done_cnt", done_cnt, 1);

    // mid-frame restart flushes FIFO, clears err, ignores same-cycle pixel
    start_frame(2, 1, 1'b0);
    wbusy = 1'b1;
    for (int i = 0; i < 4; i++) drive_pix(80 + i, 1'b1);
    drive_pix(84, 1'b0);
    check("mid_err_pre", int'(err), 1);
    start_frame(2, 1, 1'b1);
    check("mid_flush_wen", int'(wen_img), 0);
    check("mid_err_cleared", int'(err), 0);
    wbusy = 1'b0;
    drive_pix(90, 1'b1);
    check("mid_latency", int'({wen_img, wdat_img, x_addr_img, y_addr_img}), int'({1'b1, 8'd90, 8'd0, 8'd0}));
    for (int i = 1; i < 6; i++) drive_pix(90 + i, 1'b1);
    drain("mid");
    check("mid_done_cnt", done_cnt, 1);
    check("mid_err_final", int'(err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/blur_writeback.md
# blur_writeback

Write-back stage for the Gaussian blur pipeline. It accepts the blurred-pixel stream produced by the convolution engine, buffers it in a small FIFO, and writes each pixel into the output image memory. It generates the output write addresses in the same traversal order the convolution engine uses to read its input. It signals frame completion once the last pixel of the frame has been committed to memory.

## Interface
Parameters:
- MEM_W, 200, maximum image dimension; ADDR_W = $clog2(MEM_W)
- FIFO_DEPTH, 4, pixel buffer entries (power of 2, ≥2)

Ports:
- clk  in  1  system clock
- n_rst  in  1  reset, asynchronous, active-low
- new_trans  in  1  frame start pulse; flushes FIFO and resets position/flags
- max_x  in  ADDR_W  last column index (width-1); sampled on new_trans
- max_y  in  ADDR_W  last row index (height-1); sampled on new_trans
- pix_valid  in  1  one-cycle strobe, blurred pixel available (driven by blur_complete)
- pix_data  in  8  blurred pixel value
- wbusy  in  1  memory cannot accept a write this cycle
- wen_img  out  1  write enable
- wdat_img  out  8  write data
- x_addr_img  out  ADDR_W  write column
- y_addr_img  out  ADDR_W  write row
- frame_done  out  1  one-cycle pulse after the final pixel is written
- err  out  1  sticky: pixel dropped (overflow or excess pixel)

## Operation
- States: IDLE, ACTIVE, DONE.
  - IDLE → ACTIVE on new_trans.
  - ACTIVE → DONE on the write of pixel index (max_x+1)(max_y+1)-1.
  - DONE → ACTIVE on new_trans.
  - pix_valid in IDLE or DONE: pixel discarded, err=1.
- Enqueue in ACTIVE when pix_valid=1 and (FIFO not full, or a write completes the same cycle).
  - Otherwise the pixel is dropped and err=1.
  - Pixels beyond the frame count are dropped and set err.
- Write handshake:
  - wen_img=1 whenever the FIFO is non-empty in ACTIVE.
  - The write completes in a cycle with wen_img=1 and wbusy=0.
  - While wbusy=1, wen_img, wdat_img and the addresses hold stable.
- Address generator advances only on a completed write; it is not tied to enqueue. Serpentine order (default):
  - Even rows x counts 0→max_x; odd rows x counts max_x→0.
  - At a row end, y increments and x holds.
- Pixel count is tracked as x/y position only; no multiplier is used. The last pixel is row max_y at column max_x (max_y even) or column 0 (max_y odd).
- new_trans in any state, including mid-frame:
  - Empties the FIFO, sets x=y=0, clears err, and enters ACTIVE.
  - A pix_valid in the same cycle is ignored without setting err.
- max_x=max_y=0 is legal: one-pixel frame.

## Timing
- Reset values: wen_img=0, wdat_img=0, x_addr_img=0, y_addr_img=0, frame_done=0, err=0, state IDLE, FIFO empty.
- Latency: pixel enqueued at cycle N into an empty FIFO → wen_img=1 with that data at cycle N+1. Outputs are registered from the FIFO head.
- Throughput: one write per cycle with wbusy=0.
- Simultaneous enqueue and write on a full FIFO: both occur; occupancy is unchanged and err is not set.
- frame_done rises the cycle after the final write completes, lasts exactly one cycle, and wen_img=0 that cycle.
- err is set the cycle after the offending pix_valid. It holds until new_trans or reset.

## Configuration
- BLUR_WB_RASTER_EN defined: addresses follow raster order. Every row x counts 0→max_x, then x=0 and y increments. The last pixel is (max_x, max_y).
- Undefined: serpentine order as above, matching the convolution read traversal.
- All other behaviour is identical in both builds.

## Test plan
- Serpentine frame: max_x=2, max_y=1, six pix_valid pulses with data 10..15, wbusy=0 → writes (0,0)=10, (1,0)=11, (2,0)=12, (2,1)=13, (1,1)=14, (0,1)=15; frame_done one cycle after the 6th write; err=0.
- Backpressure: wbusy=1 for 5 cycles while 4 pixels arrive (FIFO_DEPTH=4) → wen/addr/data held stable; a 5th pixel while full → err=1. Release wbusy → the 4 buffered pixels are written in order.
- Full + simultaneous write: FIFO full, wbusy=0, pix_valid=1 → pixel accepted, occupancy stays 4, err=0.
- Mid-frame new_trans after 3 of 6 pixels → FIFO empty, next write at (0,0), err cleared, frame_done only after 6 further writes.
- Excess and idle pixels: pix_valid in IDLE, or a 7th pixel after a 6-pixel frame → no write, err=1.
- BLUR_WB_RASTER_EN build: max_x=2, max_y=1 → writes (0,0),(1,0),(2,0),(0,1),(1,1),(2,1); one-pixel frame (0,0) → single write then frame_done.
